// File: rtl/mdu_seq.sv
// Multi-cycle RV32M sequencer for MUL (low word), DIVU and REMU.
// Iterates by borrowing the shared 32-bit alu: add for multiply, subtract for divide.
module mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic [XLEN-1:0] alu_x,
  output logic [XLEN-1:0] alu_y,
  output logic [3:0]      alu_fn,
  input  logic [XLEN-1:0] alu_out
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid holds its payload stable until that edge, and ready may be anything.

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [1:0] OP_MUL  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_RSVD = 2'd3;

  state_t          state;
  logic [4:0]      count;
  logic [1:0]      op;
  // acc: product accumulator / partial remainder; opa: multiplicand / quotient;
  // opb: multiplier / divisor.
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;

  logic [XLEN-1:0] sh;
  logic            top;
  logic            borrow;
  logic            take;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] acc_mul;

  always_comb begin
    sh      = {acc[XLEN-2:0], opa[XLEN-1]};
    top     = acc[XLEN-1];
    // Unsigned sh < opb, recovered from the sign bits of the 32-bit difference.
    borrow  = (~sh[XLEN-1] & opb[XLEN-1]) |
              (~(sh[XLEN-1] ^ opb[XLEN-1]) & alu_out[XLEN-1]);
    take    = top | ~borrow;
    rem_nxt = take ? alu_out : sh;
    quo_nxt = {opa[XLEN-2:0], take};
    acc_mul = opb[0] ? alu_out : acc;
  end

  always_comb begin
    alu_x  = '0;
    alu_y  = '0;
    alu_fn = 4'h0;
    case (state)
      S_MUL: begin
        alu_x  = acc;
        alu_y  = opa;
        alu_fn = 4'h0;
      end
      S_DIV: begin
        alu_x  = sh;
        alu_y  = opb;
        alu_fn = 4'h8;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      count     <= '0;
      op        <= '0;
      acc       <= '0;
      opa       <= '0;
      opb       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            op        <= req_op;
            count     <= 5'd31;
            acc       <= '0;
            opa       <= req_a;
            opb       <= req_b;
            if (req_op == OP_MUL) begin
              state <= S_MUL;
            end else if (req_op == OP_RSVD) begin
              state    <= S_DONE;
              rsp_data <= '0;
            end else if (req_b == '0) begin
              state    <= S_DONE;
              rsp_data <= (req_op == OP_DIVU) ? '1 : req_a;
            end else begin
              state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          acc   <= acc_mul;
          opa   <= opa << 1;
          opb   <= opb >> 1;
          count <= count - 5'd1;
          if (count == 5'd0) begin
            state    <= S_DONE;
            rsp_data <= acc_mul;
          end
        end
        S_DIV: begin
          acc   <= rem_nxt;
          opa   <= quo_nxt;
          count <= count - 5'd1;
          if (count == 5'd0) begin
            state    <= S_DONE;
            rsp_data <= (op == OP_DIVU) ? quo_nxt : rem_nxt;
          end
        end
        S_DONE: begin
          // First DONE cycle raises rsp_valid; the result was latched on entry.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq with a behavioural alu and an expected-result queue.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [31:0] alu_x;
  logic [31:0] alu_y;
  logic [3:0]  alu_fn;
  logic [31:0] alu_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  mdu_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_fn    (alu_fn),
    .alu_out   (alu_out)
  );

  assign alu_out = (alu_fn == 4'h8) ? (alu_x - alu_y) : (alu_x + alu_y);

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Driver: present a request at a falling edge and hold it through the accepting edge.
  task automatic start_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("req_ready_after_accept", {31'd0, req_ready}, 32'd0);
  endtask

  // Waits for the response, checks latency / alu use / data, holds off for 'hold'
  // cycles, then takes the response.
  task automatic wait_rsp(input string tag, input int exp_lat, input int exp_n8, input int hold);
    int lat;
    int n8;
    int nbad;
    logic [31:0] want;
    logic [31:0] held;
    lat = 0;
    n8 = 0;
    nbad = 0;
    while (!rsp_valid && lat < 100) begin
      if (alu_fn == 4'h8) n8++;
      else if (alu_fn != 4'h0) nbad++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_sub_cycles"}, n8, exp_n8);
    chk({tag, "_bad_fn_cycles"}, nbad, 0);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    chk({tag, "_data"}, rsp_data, want);
    held = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == 3) begin
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_a     = 32'd9;
        req_b     = 32'd9;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk({tag, "_hold_data"}, rsp_data, held);
      chk({tag, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
      chk({tag, "_hold_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({tag, "_rsp_valid_after_take"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_req_ready_after_take"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat,
                     input int n8, input int hold);
    exp_q.push_back(exp);
    start_req(op, a, b);
    wait_rsp(tag, lat, n8, hold);
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_alu_x", alu_x, 32'd0);
    chk("reset_alu_y", alu_y, 32'd0);
    chk("reset_alu_fn", {28'd0, alu_fn}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("mul_7x6",      2'd0, 32'd7,          32'd6,          32'd42,         33, 0,  10);
    run("mul_ffxff",    2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  33, 0,  0);
    run("mul_x0",       2'd0, 32'h1234_5678,  32'd0,          32'd0,          33, 0,  0);
    run("divu_100_7",   2'd1, 32'd100,        32'd7,          32'd14,         33, 32, 0);
    run("remu_100_7",   2'd2, 32'd100,        32'd7,          32'd2,          33, 32, 0);
    run("divu_8000_3",  2'd1, 32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  33, 32, 0);
    run("remu_8000_3",  2'd2, 32'h8000_0000,  32'd3,          32'd2,          33, 32, 0);
    run("divu_top",     2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          33, 32, 0);
    run("remu_top",     2'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          33, 32, 0);
    run("divu_by0",     2'd1, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  0,  0);
    run("remu_by0",     2'd2, 32'd5,          32'd0,          32'd5,          1,  0,  0);
    run("op3",          2'd3, 32'd77,         32'd11,         32'd0,          1,  0,  0);

    // Reset while dividing: count is 20 after the 11th iteration edge.
    start_req(2'd1, 32'd1000, 32'd7);
    repeat (11) @(posedge clk);
    #2;
    chk("middiv_alu_fn_before_reset", {28'd0, alu_fn}, 32'h8);
    rst_n = 1'b0;
    #1;
    chk("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midreset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midreset_alu_x", alu_x, 32'd0);
    chk("midreset_alu_y", alu_y, 32'd0);
    chk("midreset_alu_fn", {28'd0, alu_fn}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("mul_3x5_after_reset", 2'd0, 32'd3, 32'd5, 32'd15, 33, 0, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
